// File: rtl/lvds_rx_word_align_if.sv
// Lane-side bundle of the LVDS word aligner: ISERDES word in, IDELAY/BITSLIP
// controls out, plus the aligned payload and training status.
interface lvds_rx_word_align_if #(
  parameter int SERI_FACTOR = 10
);
  logic [SERI_FACTOR-1:0] data_in;
  logic [4:0]             tap_value;
  logic                   tap_load;
  logic                   bitslip;
  logic                   aligned;
  logic                   align_err;
  logic [SERI_FACTOR-1:0] data_out;
  logic                   data_valid;

  // The aligner drives the lane controls and the payload.
  modport master (
    input  data_in,
    output tap_value, tap_load, bitslip, aligned, align_err, data_out, data_valid
  );

  // The lane (ISERDES/IDELAY) and the payload consumer.
  modport slave (
    output data_in,
    input  tap_value, tap_load, bitslip, aligned, align_err, data_out, data_valid
  );
endinterface

// File: rtl/lvds_rx_word_align.sv
// Training/alignment controller for one LVDS lane: scans all 32 IDELAY taps for
// the longest stable window, loads its centre, then bitslips to the training word.
module lvds_rx_word_align #(
  parameter int                     SERI_FACTOR   = 10,
  parameter logic [SERI_FACTOR-1:0] TRAIN_PATTERN = 10'h3F0,
  parameter int                     SETTLE_CYC    = 8,
  parameter int                     SAMPLE_LEN    = 16,
  parameter int                     SLIP_WAIT_CYC = 4
) (
  input  logic                 rx_clkdiv,
  input  logic                 reset_n,
  input  logic                 idelay_rdy,
  input  logic                 retrain,
  lvds_rx_word_align_if.master bus
);

  localparam int SLIP_W = $clog2(SERI_FACTOR + 1);

  typedef enum logic [3:0] {
    S_WAIT_RDY,
    S_SET_TAP,
    S_SETTLE,
    S_SAMPLE,
    S_NEXT_TAP,
    S_SET_CENTER,
    S_CENTER_SETTLE,
    S_SLIP_CHECK,
    S_SLIP_WAIT,
    S_ALIGNED,
    S_FAIL
  } state_e;

  state_e state_q, state_d;

  logic rdy_meta_q, rdy_s_q;

  // Scan bookkeeping
  logic [4:0]             tap_q, tap_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [SERI_FACTOR-1:0] ref_q, ref_d;
  logic                   good_q, good_d;
  logic [4:0]             run_start_q, run_start_d;
  logic [5:0]             run_len_q, run_len_d;
  logic [4:0]             best_start_q, best_start_d;
  logic [5:0]             best_len_q, best_len_d;
  logic [SLIP_W-1:0]      slip_cnt_q, slip_cnt_d;

  // Registered outputs
  logic [4:0]             tap_value_q, tap_value_d;
  logic                   tap_load_q, tap_load_d;
  logic                   bitslip_q, bitslip_d;
  logic                   aligned_q, aligned_d;
  logic                   align_err_q, align_err_d;
  logic [SERI_FACTOR-1:0] data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;

  logic       good_now;
  logic       run_better;
  logic [4:0] fin_start;
  logic [5:0] fin_len;
  logic [4:0] centre;
  logic       clear_all;

  // The first sampled word is its own reference, so it always counts as good.
  assign good_now   = (cnt_q == 8'd0) || (good_q && (bus.data_in == ref_q));
  // Strictly longer only: on a tie the earlier window stays the best one.
  assign run_better = run_len_q > best_len_q;
  assign fin_start  = run_better ? run_start_q : best_start_q;
  assign fin_len    = run_better ? run_len_q : best_len_q;
  assign centre     = fin_start + 5'((fin_len - 6'd1) >> 1);
  assign clear_all  = !rdy_s_q || (retrain && (state_q != S_WAIT_RDY));

  // NOTE: every always_comb variable gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    ref_d        = ref_q;
    good_d       = good_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    slip_cnt_d   = slip_cnt_q;

    unique case (state_q)
      S_WAIT_RDY: begin
        if (rdy_s_q) begin
          tap_d        = 5'd0;
          cnt_d        = 8'd0;
          run_start_d  = 5'd0;
          run_len_d    = 6'd0;
          best_start_d = 5'd0;
          best_len_d   = 6'd0;
          state_d      = S_SET_TAP;
        end
      end
      S_SET_TAP: begin
        cnt_d   = 8'd0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 8'(SETTLE_CYC - 1)) begin
          cnt_d   = 8'd0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        good_d = good_now;
        if (cnt_q == 8'd0) ref_d = bus.data_in;
        if (cnt_q == 8'(SAMPLE_LEN - 1)) begin
          cnt_d   = 8'd0;
          state_d = S_NEXT_TAP;
          if (good_now) begin
            if (run_len_q == 6'd0) run_start_d = tap_q;
            run_len_d = run_len_q + 6'd1;
          end else begin
            if (run_better) begin
              best_start_d = run_start_q;
              best_len_d   = run_len_q;
            end
            run_len_d = 6'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_NEXT_TAP: begin
        if (tap_q != 5'd31) begin
          tap_d   = tap_q + 5'd1;
          state_d = S_SET_TAP;
        end else begin
          // A window still open at tap 31 is closed here; taps do not wrap.
          best_start_d = fin_start;
          best_len_d   = fin_len;
          run_len_d    = 6'd0;
          state_d      = (fin_len == 6'd0) ? S_FAIL : S_SET_CENTER;
        end
      end
      S_SET_CENTER: begin
        cnt_d   = 8'd0;
        state_d = S_CENTER_SETTLE;
      end
      S_CENTER_SETTLE: begin
        if (cnt_q == 8'(SETTLE_CYC - 1)) begin
          cnt_d      = 8'd0;
          slip_cnt_d = '0;
          state_d    = S_SLIP_CHECK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SLIP_CHECK: begin
        if (bus.data_in == TRAIN_PATTERN) begin
          state_d = S_ALIGNED;
        end else if (slip_cnt_q == SLIP_W'(SERI_FACTOR)) begin
          state_d = S_FAIL;
        end else begin
          slip_cnt_d = slip_cnt_q + SLIP_W'(1);
          cnt_d      = 8'd0;
          state_d    = S_SLIP_WAIT;
        end
      end
      S_SLIP_WAIT: begin
        if (cnt_q == 8'(SLIP_WAIT_CYC - 1)) begin
          cnt_d   = 8'd0;
          state_d = S_SLIP_CHECK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ALIGNED: state_d = S_ALIGNED;
      S_FAIL:    state_d = S_FAIL;
      default:   state_d = S_WAIT_RDY;
    endcase

    // Loss of ready beats a retrain request; both restart from a clean scan.
    if (clear_all) begin
      tap_d        = 5'd0;
      cnt_d        = 8'd0;
      good_d       = 1'b0;
      run_start_d  = 5'd0;
      run_len_d    = 6'd0;
      best_start_d = 5'd0;
      best_len_d   = 6'd0;
      slip_cnt_d   = '0;
      state_d      = rdy_s_q ? S_SET_TAP : S_WAIT_RDY;
    end
  end

  // Outputs are registered and decoded from the state being entered, so each
  // strobe lines up with the first cycle of its state.
  always_comb begin
    tap_value_d  = tap_value_q;
    tap_load_d   = 1'b0;
    bitslip_d    = 1'b0;
    aligned_d    = (state_d == S_ALIGNED);
    data_valid_d = (state_d == S_ALIGNED);
    align_err_d  = (state_d == S_FAIL);
    data_out_d   = bus.data_in;

    if (state_d == S_SET_TAP) begin
      tap_value_d = tap_d;
      tap_load_d  = 1'b1;
    end else if (state_d == S_SET_CENTER) begin
      tap_value_d = centre;
      tap_load_d  = 1'b1;
    end else if (state_d == S_WAIT_RDY) begin
      tap_value_d = 5'd0;
    end

    if ((state_q == S_SLIP_CHECK) && (state_d == S_SLIP_WAIT)) bitslip_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge rx_clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      rdy_meta_q   <= 1'b0;
      rdy_s_q      <= 1'b0;
      state_q      <= S_WAIT_RDY;
      tap_q        <= 5'd0;
      cnt_q        <= 8'd0;
      ref_q        <= '0;
      good_q       <= 1'b0;
      run_start_q  <= 5'd0;
      run_len_q    <= 6'd0;
      best_start_q <= 5'd0;
      best_len_q   <= 6'd0;
      slip_cnt_q   <= '0;
      tap_value_q  <= 5'd0;
      tap_load_q   <= 1'b0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      align_err_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      rdy_meta_q   <= idelay_rdy;
      rdy_s_q      <= rdy_meta_q;
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      ref_q        <= ref_d;
      good_q       <= good_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      slip_cnt_q   <= slip_cnt_d;
      tap_value_q  <= tap_value_d;
      tap_load_q   <= tap_load_d;
      bitslip_q    <= bitslip_d;
      aligned_q    <= aligned_d;
      align_err_q  <= align_err_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.tap_value  = tap_value_q;
  assign bus.tap_load   = tap_load_q;
  assign bus.bitslip    = bitslip_q;
  assign bus.aligned    = aligned_q;
  assign bus.align_err  = align_err_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;

  a_strobe_excl: assert property (@(posedge rx_clkdiv) disable iff (!reset_n)
    !(tap_load_q && bitslip_q));
  a_status_excl: assert property (@(posedge rx_clkdiv) disable iff (!reset_n)
    !(aligned_q && align_err_q));

endmodule

// File: doc/lvds_rx_word_align.md
Name: lvds_rx_word_align

Overview:
- Training and alignment controller for one LVDS data lane in the `rx_clkdiv` domain.
- Sits downstream of the LVDS rx clock generator. Consumes its `idelayCtrl_rdy` and the parallel word from the lane's ISERDES.
- Drives the lane's IDELAY tap and ISERDES bitslip. Centres the sampling point, then slips until the training pattern appears, then forwards aligned words.

Parameters:
- SERI_FACTOR, 10, deserialised word width in bits; also the maximum number of bitslips tried.
- TRAIN_PATTERN, 10'h3F0, expected training word (SERI_FACTOR bits).
- SETTLE_CYC, 8, wait cycles after any tap load before sampling (1..255).
- SAMPLE_LEN, 16, consecutive identical words required to mark a tap good (2..255).
- SLIP_WAIT_CYC, 4, wait cycles after a bitslip pulse before re-checking (1..15).

Ports:
- rx_clkdiv, in, 1, parallel-word clock; the only clock.
- reset_n, in, 1, asynchronous, active-low reset.
- idelay_rdy, in, 1, IDELAYCTRL ready AND MMCM locked; asynchronous, synchronised internally.
- retrain, in, 1, single-cycle request to restart training.
- data_in, in, SERI_FACTOR, ISERDES parallel output.
- tap_value, out, 5, IDELAY CNTVALUEIN.
- tap_load, out, 1, one-cycle IDELAY LD strobe.
- bitslip, out, 1, one-cycle ISERDES BITSLIP strobe.
- aligned, out, 1, training succeeded.
- align_err, out, 1, training failed: no good tap, or no match after SERI_FACTOR slips.
- data_out, out, SERI_FACTOR, registered data_in.
- data_valid, out, 1, data_out is aligned payload.

Behaviour:
- Reset values: all outputs 0; state WAIT_RDY; all counters 0.
- idelay_rdy passes through a 2-flop synchroniser (rdy_s). If rdy_s is low in any state, the next state is WAIT_RDY and all outputs return to reset values, except data_out, which keeps registering.
- WAIT_RDY: on rdy_s=1, set tap counter t=0 and clear the best-run registers, then go to SET_TAP.
- SET_TAP: tap_value<=t; tap_load=1 for this single cycle; go to SETTLE.
- SETTLE: count SETTLE_CYC cycles; go to SAMPLE.
- SAMPLE:
  - Capture the first word as the reference.
  - The tap is good if data_in equals the reference on all SAMPLE_LEN cycles, counting the first.
  - Maintain the current run start/length.
  - On a bad tap, close the run; a run replaces the best run only if strictly longer, so ties keep the earliest.
  - Go to NEXT_TAP.
- NEXT_TAP:
  - If t<31: t<=t+1, go to SET_TAP.
  - Else close any open run. A run ending at tap 31 is counted; there is no wrap to tap 0.
  - If best length=0, go to FAIL. Else centre = best_start + (best_len-1)>>1 and go to SET_CENTER.
- SET_CENTER: tap_value<=centre; tap_load pulse; SETTLE_CYC wait; then SLIP_CHECK with slip count=0.
- SLIP_CHECK:
  - If data_in==TRAIN_PATTERN, go to ALIGNED.
  - Else if slip count==SERI_FACTOR, go to FAIL.
  - Else bitslip=1 for one cycle, increment slip count, go to SLIP_WAIT.
- SLIP_WAIT: SLIP_WAIT_CYC cycles; return to SLIP_CHECK.
- ALIGNED: aligned=1, data_valid=1. Hold tap_value until retrain or rdy loss.
- FAIL: align_err=1, aligned=0. Hold until retrain or rdy loss.
- retrain=1 in any state other than WAIT_RDY:
  - Clears aligned, align_err, data_valid and all counters; t=0; next state SET_TAP.
  - retrain takes priority over every other transition, except rdy_s=0, which wins.
- data_out <= data_in every cycle, 1-cycle latency. data_valid is registered and aligned with data_out; it rises on the cycle after the ALIGNED entry decision.
- tap_load and bitslip never assert in the same cycle. Neither asserts outside the states named above.

Test Plan:
- Hold idelay_rdy=0 for 50 cycles, then release; release reset_n mid-cycle. -> All outputs 0 until 2 cycles after idelay_rdy rises; the first tap_load carries tap_value=0.
- Lane model stable on taps 6..17, glitching elsewhere; data already equals 10'h3F0. -> 32 tap_load pulses during the scan, then tap_value=11 (the centre of 6..17); aligned=1 with zero bitslip pulses.
- Stable window 0..31; lane model word rotated 3 bits from 10'h3F0. -> Centre tap 15; exactly 3 bitslip pulses, each followed by ≥4 idle cycles; aligned=1; data_valid=1 and data_out=10'h3F0 on the next cycle.
- Stable windows 2..4 and 20..22. -> Tie keeps the earliest run; tap_value=3.
- No stable tap, or a pattern never matching. -> align_err=1 after the scan, or after exactly 10 bitslips; aligned=0; no further strobes.
- retrain pulse while ALIGNED, and separately drop idelay_rdy mid-SAMPLE. -> Retrain: aligned and data_valid fall next cycle, rescan restarts at tap_value=0. Rdy drop: state returns to WAIT_RDY, outputs cleared.
